// File: rtl/iir_biquad_tdm.sv
// Direct-form-I biquad shared across CH channels. A single signed multiplier
// is stepped through the five taps of one sample. The coefficients are
// programmable at run time and common to all channels. Each channel keeps its
// own two-deep input and output history.
module iir_biquad_tdm #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int CH   = 4,
  parameter int CHW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [DW-1:0]  in_data,
  input  logic [CHW-1:0]        in_chan,
  input  logic                  coef_we,
  input  logic [2:0]            coef_addr,
  input  logic signed [CW-1:0]  coef_data,
  output logic                  coef_err,
  input  logic                  clr_hist,
  output logic                  out_valid,
  output logic signed [DW-1:0]  out_data,
  output logic [CHW-1:0]        out_chan,
  output logic                  sat_flag
);

  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + 3;
  localparam logic signed [ACCW-1:0] RND_C = {{(ACCW-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [ACCW-1:0] MAX_C = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MIN_C = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [CW-1:0]   ONE_C = {{(CW-1){1'b0}}, 1'b1} << FRAC;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;

  state_t                 state_q;
  logic [2:0]             k_q;
  logic                   rdy_q;
  logic signed [DW-1:0]   x_q;
  logic [CHW-1:0]         chan_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [CW-1:0]   b0_q, b1_q, b2_q, a1_q, a2_q;
  logic signed [DW-1:0]   x1_q [CH];
  logic signed [DW-1:0]   x2_q [CH];
  logic signed [DW-1:0]   y1_q [CH];
  logic signed [DW-1:0]   y2_q [CH];
  logic                   out_valid_q, sat_q, coef_err_q;
  logic signed [DW-1:0]   out_data_q;
  logic [CHW-1:0]         out_chan_q;

  logic                   accept_s, idle_s, coef_ok_s, coef_wr_s, coef_drop_s, clr_s;
  logic signed [CW-1:0]   coef_sel_s;
  logic signed [DW-1:0]   samp_sel_s;
  logic                   sub_s;
  logic signed [PW-1:0]   prod_s;
  logic signed [ACCW-1:0] prod_ext_s, acc_d, rnd_s, shr_s;
  logic signed [DW-1:0]   y_d;
  logic                   sat_d;

  // A pending history clear takes priority over a new sample, so ready drops.
  assign in_ready    = rdy_q & ~clr_hist;
  assign accept_s    = in_valid & in_ready;
  assign idle_s      = (state_q == S_IDLE);
  assign coef_ok_s   = coef_we & (coef_addr < 3'd5);
  assign coef_wr_s   = coef_ok_s & idle_s & ~accept_s;
  assign coef_drop_s = coef_ok_s & ~coef_wr_s;
  assign clr_s       = clr_hist & idle_s & ~accept_s;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign sat_flag  = sat_q;
  assign coef_err  = coef_err_q;

  // Select the coefficient/sample pair for tap k; feedback taps are subtracted.
  always_comb begin
    coef_sel_s = b0_q;
    samp_sel_s = x_q;
    sub_s      = 1'b0;
    case (k_q)
      3'd0: begin coef_sel_s = b0_q; samp_sel_s = x_q;          sub_s = 1'b0; end
      3'd1: begin coef_sel_s = b1_q; samp_sel_s = x1_q[chan_q]; sub_s = 1'b0; end
      3'd2: begin coef_sel_s = b2_q; samp_sel_s = x2_q[chan_q]; sub_s = 1'b0; end
      3'd3: begin coef_sel_s = a1_q; samp_sel_s = y1_q[chan_q]; sub_s = 1'b1; end
      3'd4: begin coef_sel_s = a2_q; samp_sel_s = y2_q[chan_q]; sub_s = 1'b1; end
      default: begin coef_sel_s = {CW{1'b0}}; samp_sel_s = {DW{1'b0}}; sub_s = 1'b0; end
    endcase
  end

  assign prod_s     = coef_sel_s * samp_sel_s;
  assign prod_ext_s = {{(ACCW-PW){prod_s[PW-1]}}, prod_s};
  assign acc_d      = sub_s ? (acc_q - prod_ext_s) : (acc_q + prod_ext_s);
  assign rnd_s      = acc_q + RND_C;
  assign shr_s      = rnd_s >>> FRAC;

  // Clamp the rounded accumulator to the output range and flag any clamping.
  always_comb begin
    y_d   = shr_s[DW-1:0];
    sat_d = 1'b0;
    if (shr_s > MAX_C) begin
      y_d   = MAX_C[DW-1:0];
      sat_d = 1'b1;
    end else if (shr_s < MIN_C) begin
      y_d   = MIN_C[DW-1:0];
      sat_d = 1'b1;
    end else begin
      y_d   = shr_s[DW-1:0];
      sat_d = 1'b0;
    end
  end

  // Sequencer: accept in IDLE, five MAC taps, then emit and update history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      rdy_q       <= 1'b0;
      x_q         <= {DW{1'b0}};
      chan_q      <= {CHW{1'b0}};
      acc_q       <= {ACCW{1'b0}};
      b0_q        <= ONE_C;
      b1_q        <= {CW{1'b0}};
      b2_q        <= {CW{1'b0}};
      a1_q        <= {CW{1'b0}};
      a2_q        <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
      out_chan_q  <= {CHW{1'b0}};
      sat_q       <= 1'b0;
      coef_err_q  <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        x1_q[i] <= {DW{1'b0}};
        x2_q[i] <= {DW{1'b0}};
        y1_q[i] <= {DW{1'b0}};
        y2_q[i] <= {DW{1'b0}};
      end
    end else begin
      coef_err_q  <= coef_drop_s;
      out_valid_q <= 1'b0;
      if (coef_wr_s) begin
        case (coef_addr)
          3'd0: b0_q <= coef_data;
          3'd1: b1_q <= coef_data;
          3'd2: b2_q <= coef_data;
          3'd3: a1_q <= coef_data;
          3'd4: a2_q <= coef_data;
          default: ;
        endcase
      end
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (accept_s) begin
            x_q     <= in_data;
            chan_q  <= in_chan;
            acc_q   <= {ACCW{1'b0}};
            k_q     <= 3'd0;
            rdy_q   <= 1'b0;
            state_q <= S_MAC;
          end else if (clr_s) begin
            for (int i = 0; i < CH; i++) begin
              x1_q[i] <= {DW{1'b0}};
              x2_q[i] <= {DW{1'b0}};
              y1_q[i] <= {DW{1'b0}};
              y2_q[i] <= {DW{1'b0}};
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 3'd1;
          if (k_q == 3'd4) begin
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          out_valid_q    <= 1'b1;
          out_data_q     <= y_d;
          out_chan_q     <= chan_q;
          sat_q          <= sat_d;
          x2_q[chan_q]   <= x1_q[chan_q];
          x1_q[chan_q]   <= x_q;
          y2_q[chan_q]   <= y1_q[chan_q];
          y1_q[chan_q]   <= y_d;
          rdy_q          <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
